// File: rtl/arbiter_1_to_n_response_memory_if.sv
// Bus bundle for the 1-to-N response arbiter: ingress response, per-destination egress
// responses with their read enables, and status toward the memory side.
interface arbiter_1_to_n_response_memory_if #(
    parameter int unsigned NUM_MEMORY_RECEIVER = 2,
    parameter int unsigned DATA_WIDTH          = 32
);
    logic                                           response_in_valid;
    logic [DATA_WIDTH-1:0]                          response_in_payload;
    logic [NUM_MEMORY_RECEIVER-1:0]                 rd_en;
    // {empty, prog_full} of the ingress FIFO
    logic [1:0]                                     fifo_response_signals_out;
    logic [NUM_MEMORY_RECEIVER-1:0]                 response_out_valid;
    logic [NUM_MEMORY_RECEIVER-1:0][DATA_WIDTH-1:0] response_out_payload;
    logic                                           fifo_setup_signal;
    logic [15:0]                                    error_drop_count;

    modport master (
        output response_in_valid, response_in_payload, rd_en,
        input  fifo_response_signals_out, response_out_valid, response_out_payload,
        input  fifo_setup_signal, error_drop_count
    );

    modport slave (
        input  response_in_valid, response_in_payload, rd_en,
        output fifo_response_signals_out, response_out_valid, response_out_payload,
        output fifo_setup_signal, error_drop_count
    );
endinterface

// File: rtl/arbiter_1_to_n_response_memory.sv
// Routes memory responses from one ingress FIFO to N per-destination egress FIFOs using an
// ID field in the payload; out-of-range IDs are discarded and counted (saturating).
module arbiter_1_to_n_response_memory #(
    parameter int unsigned NUM_MEMORY_RECEIVER = 2,
    parameter int unsigned FIFO_ARBITER_DEPTH  = 8,
    parameter int unsigned FIFO_WRITE_DEPTH    = 2 ** $clog2(FIFO_ARBITER_DEPTH + 9),
    parameter int unsigned PROG_THRESH         = (FIFO_WRITE_DEPTH / 2) + 3,
    parameter int unsigned ID_LSB              = 0,
    parameter int unsigned DATA_WIDTH          = 32
) (
    input logic                             ap_clk,
    input logic                             areset,
    arbiter_1_to_n_response_memory_if.slave bus
);
    localparam int unsigned N          = NUM_MEMORY_RECEIVER;
    localparam int unsigned IdW        = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IngAw      = $clog2(FIFO_WRITE_DEPTH);
    localparam int unsigned IngCntW    = IngAw + 1;
    localparam int unsigned EgDepth    = 16;
    localparam int unsigned EgAw       = 4;
    localparam int unsigned EgCntW     = EgAw + 1;
    localparam int unsigned EgThresh   = 12;
    localparam int unsigned BusyCycles = 4;

    typedef enum logic {StIdle, StDispatch} state_e;

    logic                  rst_q;
    logic [2:0]            busy_cnt_q;
    logic                  fifo_busy;
    logic                  in_valid_q;
    logic [DATA_WIDTH-1:0] in_payload_q;
    logic [N-1:0]          rd_en_q;

    always_ff @(posedge ap_clk) begin
        rst_q <= areset;
    end

    // All internal FIFOs share one reset, so a single busy window stands in for every rst_busy.
    always_ff @(posedge ap_clk) begin
        if (rst_q) begin
            busy_cnt_q <= 3'(BusyCycles);
        end else if (busy_cnt_q != '0) begin
            busy_cnt_q <= busy_cnt_q - 3'd1;
        end
    end
    assign fifo_busy = rst_q | (busy_cnt_q != '0);

    always_ff @(posedge ap_clk) begin
        if (rst_q) begin
            in_valid_q <= 1'b0;
            rd_en_q    <= '0;
        end else begin
            in_valid_q <= bus.response_in_valid;
            rd_en_q    <= bus.rd_en;
        end
        in_payload_q <= bus.response_in_payload;
    end

    // Ingress FIFO (depth assumed a power of two so pointers wrap naturally)
    logic [DATA_WIDTH-1:0] ing_mem_q [FIFO_WRITE_DEPTH];
    logic [IngAw-1:0]      ing_wptr_q, ing_rptr_q;
    logic [IngCntW-1:0]    ing_cnt_q;
    logic                  ing_empty, ing_full, ing_pf, ing_push, ing_pop;

    assign ing_empty = (ing_cnt_q == '0);
    assign ing_full  = (ing_cnt_q == IngCntW'(FIFO_WRITE_DEPTH));
    assign ing_pf    = (ing_cnt_q >= IngCntW'(PROG_THRESH));
    assign ing_push  = in_valid_q && !ing_full && !fifo_busy;

    always_ff @(posedge ap_clk) begin
        if (rst_q) begin
            ing_wptr_q <= '0;
            ing_rptr_q <= '0;
            ing_cnt_q  <= '0;
        end else begin
            if (ing_push) ing_wptr_q <= ing_wptr_q + 1'b1;
            if (ing_pop)  ing_rptr_q <= ing_rptr_q + 1'b1;
            ing_cnt_q <= ing_cnt_q + IngCntW'(ing_push) - IngCntW'(ing_pop);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ing_push) ing_mem_q[ing_wptr_q] <= in_payload_q;
    end

    // Dispatch FSM
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_valid_q;
    logic [IdW-1:0]        dest;
    logic [N-1:0]          dest_hit;
    logic [N-1:0]          eg_push, eg_pf, eg_empty;
    logic                  drop_inc;

    assign dest = hold_q[ID_LSB +: IdW];

    always_comb begin
        dest_hit = '0;
        for (int unsigned i = 0; i < N; i++) begin
            dest_hit[i] = (dest == IdW'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        ing_pop  = 1'b0;
        eg_push  = '0;
        drop_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!ing_empty && !fifo_busy) begin
                    ing_pop = 1'b1;
                    state_d = StDispatch;
                end
            end
            StDispatch: begin
                if (hold_valid_q) begin
                    if (dest_hit == '0) begin
                        drop_inc = 1'b1;
                        state_d  = StIdle;
                    end else if ((dest_hit & eg_pf) == '0) begin
                        eg_push = dest_hit;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (rst_q) begin
            state_q      <= StIdle;
            hold_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ing_pop) begin
                hold_valid_q <= 1'b1;
            end else if (state_q == StDispatch && state_d == StIdle) begin
                hold_valid_q <= 1'b0;
            end
        end
        if (ing_pop) hold_q <= ing_mem_q[ing_rptr_q];
    end

    // Egress FIFOs, one per destination, each with a registered output stage
    logic [N-1:0]                 out_valid;
    logic [N-1:0][DATA_WIDTH-1:0] out_payload;

    for (genvar g = 0; g < N; g++) begin : gen_egress
        logic [DATA_WIDTH-1:0] mem_q [EgDepth];
        logic [EgAw-1:0]       wptr_q, rptr_q;
        logic [EgCntW-1:0]     cnt_q;
        logic                  pop;
        logic                  ovalid_q;
        logic [DATA_WIDTH-1:0] opayload_q;

        assign eg_empty[g] = (cnt_q == '0);
        assign eg_pf[g]    = (cnt_q >= EgCntW'(EgThresh));
        assign pop         = rd_en_q[g] && !eg_empty[g] && !fifo_busy;

        always_ff @(posedge ap_clk) begin
            if (rst_q) begin
                wptr_q   <= '0;
                rptr_q   <= '0;
                cnt_q    <= '0;
                ovalid_q <= 1'b0;
            end else begin
                if (eg_push[g]) wptr_q <= wptr_q + 1'b1;
                if (pop)        rptr_q <= rptr_q + 1'b1;
                cnt_q    <= cnt_q + EgCntW'(eg_push[g]) - EgCntW'(pop);
                ovalid_q <= pop;
            end
        end

        always_ff @(posedge ap_clk) begin
            if (eg_push[g]) mem_q[wptr_q] <= hold_q;
            if (pop)        opayload_q    <= mem_q[rptr_q];
        end

        assign out_valid[g]   = ovalid_q;
        assign out_payload[g] = opayload_q;
    end

    // Status, setup and drop counter
    logic [1:0]  status_q;
    logic        setup_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge ap_clk) begin
        status_q <= {ing_empty, ing_pf};
        setup_q  <= fifo_busy;
        if (rst_q) begin
            drop_cnt_q <= '0;
        end else if (drop_inc && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.response_out_valid        = out_valid;
    assign bus.response_out_payload      = out_payload;
    assign bus.fifo_response_signals_out = status_q;
    assign bus.fifo_setup_signal         = setup_q;
    assign bus.error_drop_count          = drop_cnt_q;
endmodule

// File: tb/tb_arbiter_1_to_n_response_memory.sv
// Bench for the 1-to-N response arbiter: directed phases plus a randomized phase, checked
// against per-destination expected queues and an expected drop count.
module tb_arbiter_1_to_n_response_memory;
    localparam int unsigned N   = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned MAX = 512;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    arbiter_1_to_n_response_memory_if #(.NUM_MEMORY_RECEIVER(N), .DATA_WIDTH(DW)) bus ();

    arbiter_1_to_n_response_memory #(
        .NUM_MEMORY_RECEIVER(N),
        .PROG_THRESH        (7),
        .DATA_WIDTH         (DW)
    ) dut (
        .ap_clk (clk),
        .areset (areset),
        .bus    (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_mem [N][MAX];
    int          exp_cnt [N];
    int          chk_from [N];
    int          exp_drops;
    logic [31:0] obs_mem [N][MAX];
    int          obs_cnt [N];

    initial begin
        for (int p = 0; p < N; p++) obs_cnt[p] = 0;
    end

    always @(negedge clk) begin
        for (int p = 0; p < N; p++) begin
            if (bus.response_out_valid[p] === 1'b1 && obs_cnt[p] < MAX) begin
                obs_mem[p][obs_cnt[p]] = bus.response_out_payload[p];
                obs_cnt[p]++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input int unsigned id, input bit honour, input bit track);
        logic [31:0] p;
        int g = 0;
        while (honour && bus.fifo_response_signals_out[0] === 1'b1 && g < 2000) begin
            bus.rd_en = '1;
            tick();
            g++;
        end
        p = $urandom;
        p[1:0] = id[1:0];
        bus.response_in_valid   = 1'b1;
        bus.response_in_payload = p;
        tick();
        bus.response_in_valid = 1'b0;
        if (track) begin
            if (id < N) begin
                exp_mem[id][exp_cnt[id]] = p;
                exp_cnt[id]++;
            end else if (exp_drops != 32'hFFFF) begin
                exp_drops++;
            end
        end
    endtask

    function automatic bit all_done();
        for (int p = 0; p < N; p++) if (obs_cnt[p] != exp_cnt[p]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        int guard = 0;
        bus.rd_en = '1;
        while (!all_done() && guard < 3000) begin
            tick();
            guard++;
        end
        repeat (20) tick();
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < N; p++) begin
            chk($sformatf("%s_count_p%0d", tag, p), 32'(obs_cnt[p]), 32'(exp_cnt[p]));
            for (int i = chk_from[p]; i < exp_cnt[p]; i++) begin
                chk($sformatf("%s_p%0d_beat%0d", tag, p, i), obs_mem[p][i], exp_mem[p][i]);
            end
            chk_from[p] = exp_cnt[p];
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(bus.response_out_valid), 32'd0);
        chk({tag, "_status"}, 32'(bus.fifo_response_signals_out), 32'b10);
        chk({tag, "_setup"}, 32'(bus.fifo_setup_signal), 32'd1);
        chk({tag, "_drops"}, 32'(bus.error_drop_count), 32'd0);
    endtask

    task automatic wait_setup(input string tag);
        int g = 0;
        tick();
        chk({tag, "_setup_high_after_release"}, 32'(bus.fifo_setup_signal), 32'd1);
        while (bus.fifo_setup_signal !== 1'b0 && g < 100) begin
            tick();
            g++;
        end
        chk({tag, "_setup_clears"}, 32'(bus.fifo_setup_signal), 32'd0);
    endtask

    int lat1, lat2;
    int base0, base1, base_tot;

    initial begin
        for (int p = 0; p < N; p++) begin
            exp_cnt[p]  = 0;
            chk_from[p] = 0;
        end
        exp_drops               = 0;
        areset                  = 1'b1;
        bus.response_in_valid   = 1'b0;
        bus.response_in_payload = '0;
        bus.rd_en               = '0;

        // Reset values, then setup window after release
        repeat (5) tick();
        check_reset_state("reset0");
        areset = 1'b0;
        wait_setup("reset0");

        // Single ID=1 response: latency bound, constant latency, port 0 silent
        bus.rd_en = '1;
        send(1, 1'b0, 1'b1);
        lat1 = 1;
        while (bus.response_out_valid[1] !== 1'b1 && lat1 < 20) begin
            tick();
            lat1++;
        end
        chk("latency1_le_8", 32'(lat1 <= 8), 32'd1);
        drain();
        check_all("single");
        send(1, 1'b0, 1'b1);
        lat2 = 1;
        while (bus.response_out_valid[1] !== 1'b1 && lat2 < 20) begin
            tick();
            lat2++;
        end
        chk("latency_constant", 32'(lat2), 32'(lat1));
        drain();
        check_all("single2");

        // Alternating IDs 0,1 for 20 beats
        for (int k = 0; k < 20; k++) send(k % 2, 1'b1, 1'b1);
        drain();
        check_all("alt");
        chk("alt_drops", 32'(bus.error_drop_count), 32'(exp_drops));

        // Out-of-range ID 3 five times, then ID 2
        for (int k = 0; k < 5; k++) send(3, 1'b1, 1'b1);
        send(2, 1'b1, 1'b1);
        drain();
        check_all("drop");
        chk("drop_count", 32'(bus.error_drop_count), 32'(exp_drops));

        // Head-of-line blocking: port 0 stalled, 20 ID=0 then 1 ID=1
        bus.rd_en = 3'b110;
        base0 = obs_cnt[0];
        base1 = obs_cnt[1];
        for (int k = 0; k < 20; k++) send(0, 1'b0, 1'b1);
        send(1, 1'b0, 1'b1);
        repeat (60) tick();
        chk("hol_ingress_prog_full", 32'(bus.fifo_response_signals_out[0]), 32'd1);
        chk("hol_port0_silent", 32'(obs_cnt[0]), 32'(base0));
        chk("hol_port1_blocked", 32'(obs_cnt[1]), 32'(base1));
        drain();
        check_all("hol");

        // Randomized traffic with random read enables and occasional bad IDs
        for (int k = 0; k < 150; k++) begin
            bus.rd_en = 3'($urandom);
            send(($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2), 1'b1, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        check_all("rand");
        chk("rand_drops", 32'(bus.error_drop_count), 32'(exp_drops));

        // Reset with buffered responses: all of them must vanish
        bus.rd_en = '0;
        for (int k = 0; k < 6; k++) send(k % N, 1'b0, 1'b0);
        repeat (10) tick();
        base_tot = obs_cnt[0] + obs_cnt[1] + obs_cnt[2];
        areset = 1'b1;
        exp_drops = 0;
        repeat (4) tick();
        check_reset_state("reset1");
        areset = 1'b0;
        wait_setup("reset1");
        bus.rd_en = '1;
        repeat (30) tick();
        chk("no_stale_after_reset", 32'(obs_cnt[0] + obs_cnt[1] + obs_cnt[2]), 32'(base_tot));
        for (int k = 0; k < 6; k++) send($urandom_range(0, 2), 1'b1, 1'b1);
        drain();
        check_all("post_reset");
        chk("post_reset_drops", 32'(bus.error_drop_count), 32'(exp_drops));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
